// File: rtl/cook_sequencer_if.sv
// Front-panel bundle between the keypad/buttons, the display and the cook sequencer.
// The master drives the buttons and keypad. The slave is the sequencer, which drives the display and magnetron.
interface cook_sequencer_if;
    logic       startn;
    logic       stopn;
    logic       clearn;
    logic       door_closed;
    logic       digit_valid;
    logic [3:0] digit;
    logic [1:0] power;
    logic       mag_on;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [1:0] state;
    logic       done;
    logic       beep;

    modport master (
        output startn, stopn, clearn, door_closed, digit_valid, digit, power,
        input  mag_on, min_tens, min_ones, sec_tens, sec_ones, state, done, beep
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, digit_valid, digit, power,
        output mag_on, min_tens, min_ones, sec_tens, sec_ones, state, done, beep
    );
endinterface

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: MM:SS keypad entry, BCD countdown, pause/resume, power duty cycling.
// Define BEEP_EN to enable the three-pulse completion buzzer; otherwise beep is tied low.
module cook_sequencer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic           clk,
    input  logic           rst,
    cook_sequencer_if.slave panel
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COOK  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int            PW  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] TC  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] ONE = PW'(1);

    logic [1:0]    state_reg, state_next;
    logic [15:0]   time_reg, time_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [1:0]    phase_reg, phase_next;
    logic [1:0]    power_reg, power_next;
    logic          mag_reg, mag_next;
    logic [15:0]   time_dec;
    logic          tc;

    // BCD countdown; seconds-tens borrows back to 5, the other digits to 9.
    always_comb begin
        time_dec = time_reg;
        if (time_reg[3:0] != 4'd0) begin
            time_dec[3:0] = time_reg[3:0] - 4'd1;
        end else begin
            time_dec[3:0] = 4'd9;
            if (time_reg[7:4] != 4'd0) begin
                time_dec[7:4] = time_reg[7:4] - 4'd1;
            end else begin
                time_dec[7:4] = 4'd5;
                if (time_reg[11:8] != 4'd0) begin
                    time_dec[11:8] = time_reg[11:8] - 4'd1;
                end else begin
                    time_dec[11:8]  = 4'd9;
                    time_dec[15:12] = time_reg[15:12] - 4'd1;
                end
            end
        end
    end

    assign tc = (presc_reg == TC);

    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        presc_next = presc_reg;
        phase_next = phase_reg;
        power_next = power_reg;
        case (state_reg)
            ST_IDLE: begin
                if (!panel.clearn) begin
                    time_next = 16'd0;
                end else if (!panel.startn && panel.stopn && panel.door_closed && time_reg != 16'd0) begin
                    state_next = ST_COOK;
                    presc_next = '0;
                    phase_next = 2'd0;
                    power_next = panel.power;
                end else if (panel.digit_valid && panel.digit <= 4'd9) begin
                    time_next = {time_reg[11:0], panel.digit};
                end
            end
            ST_COOK: begin
                if (!panel.clearn) begin
                    state_next = ST_IDLE;
                    time_next  = 16'd0;
                end else if (!panel.stopn || !panel.door_closed) begin
                    state_next = ST_PAUSE;
                end else if (tc) begin
                    presc_next = '0;
                    phase_next = phase_reg + 2'd1;
                    time_next  = time_dec;
                    if (time_dec == 16'd0) begin
                        state_next = ST_DONE;
                    end
                end else begin
                    presc_next = presc_reg + ONE;
                end
            end
            ST_PAUSE: begin
                if (!panel.clearn || !panel.stopn) begin
                    state_next = ST_IDLE;
                    time_next  = 16'd0;
                end else if (panel.door_closed && !panel.startn) begin
                    state_next = ST_COOK;
                    power_next = panel.power;
                end
            end
            default: begin
                if (!panel.startn || !panel.stopn || !panel.clearn || !panel.door_closed) begin
                    state_next = ST_IDLE;
                end else begin
                    // Keeps running in DONE so the buzzer has a seconds base.
                    presc_next = tc ? '0 : presc_reg + ONE;
                end
            end
        endcase
        mag_next = (state_next == ST_COOK) && (phase_next <= power_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            time_reg  <= 16'd0;
            presc_reg <= '0;
            phase_reg <= 2'd0;
            power_reg <= 2'd0;
            mag_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            time_reg  <= time_next;
            presc_reg <= presc_next;
            phase_reg <= phase_next;
            power_reg <= power_next;
            mag_reg   <= mag_next;
        end
    end

`ifdef BEEP_EN
    logic [2:0] beep_sec_reg, beep_sec_next;
    logic       beep_reg, beep_next;

    // Seconds 0, 2 and 4 after entering DONE are audible.
    always_comb begin
        beep_sec_next = beep_sec_reg;
        if (state_reg != ST_DONE && state_next == ST_DONE) begin
            beep_sec_next = 3'd0;
        end else if (state_reg == ST_DONE && tc && beep_sec_reg != 3'd6) begin
            beep_sec_next = beep_sec_reg + 3'd1;
        end
        beep_next = (state_next == ST_DONE) && (beep_sec_next < 3'd6) && !beep_sec_next[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_sec_reg <= 3'd0;
            beep_reg     <= 1'b0;
        end else begin
            beep_sec_reg <= beep_sec_next;
            beep_reg     <= beep_next;
        end
    end

    assign panel.beep = beep_reg;
`else
    assign panel.beep = 1'b0;
`endif

    // The door interlock bypasses the register so the magnetron stops in the cycle the door opens.
    assign panel.mag_on   = mag_reg & panel.door_closed;
    assign panel.min_tens = time_reg[15:12];
    assign panel.min_ones = time_reg[11:8];
    assign panel.sec_tens = time_reg[7:4];
    assign panel.sec_ones = time_reg[3:0];
    assign panel.state    = state_reg;
    assign panel.done     = (state_reg == ST_DONE);
endmodule

// File: tb/tb_cook_sequencer.sv
// Randomised and directed bench for cook_sequencer against a minutes/seconds reference model.
// Honours BEEP_EN the same way as the design.
module tb_cook_sequencer;
    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cook_sequencer_if panel();
    cook_sequencer #(.TICKS_PER_SEC(T)) dut (.clk(clk), .rst(rst), .panel(panel));

    int checks = 0;
    int errors = 0;

    // Reference model: time held as integer minutes and seconds, with elapsed ticks inside the current second.
    int m_state, m_mins, m_secs, m_tick, m_phase, m_pow, m_bsec;
    bit m_mag;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_disp();
        return {4'(m_mins / 10), 4'(m_mins % 10), 4'(m_secs / 10), 4'(m_secs % 10)};
    endfunction

    function automatic logic [15:0] dut_disp();
        return {panel.min_tens, panel.min_ones, panel.sec_tens, panel.sec_ones};
    endfunction

    task automatic model_reset();
        m_state = 0; m_mins = 0; m_secs = 0; m_tick = 0;
        m_phase = 0; m_pow = 0; m_bsec = 0; m_mag = 0;
    endtask

    task automatic model_step();
        bit st, sp, cl, dr;
        st = !panel.startn;
        sp = !panel.stopn;
        cl = !panel.clearn;
        dr = panel.door_closed;
        case (m_state)
            0: begin
                if (cl) begin
                    m_mins = 0; m_secs = 0;
                end else if (st && !sp && dr && (m_mins + m_secs) != 0) begin
                    m_state = 1; m_tick = 0; m_phase = 0; m_pow = int'(panel.power);
                end else if (panel.digit_valid && panel.digit <= 4'd9) begin
                    m_mins = (m_mins % 10) * 10 + m_secs / 10;
                    m_secs = (m_secs % 10) * 10 + int'(panel.digit);
                end
            end
            1: begin
                if (cl) begin
                    m_state = 0; m_mins = 0; m_secs = 0;
                end else if (sp || !dr) begin
                    m_state = 2;
                end else if (m_tick == T - 1) begin
                    m_tick = 0;
                    m_phase = (m_phase + 1) % 4;
                    if (m_secs > 0) m_secs--;
                    else begin m_secs = 59; m_mins--; end
                    if (m_mins == 0 && m_secs == 0) begin
                        m_state = 3; m_bsec = 0;
                    end
                end else begin
                    m_tick++;
                end
            end
            2: begin
                if (cl || sp) begin
                    m_state = 0; m_mins = 0; m_secs = 0;
                end else if (dr && st) begin
                    m_state = 1; m_pow = int'(panel.power);
                end
            end
            default: begin
                if (st || sp || cl || !dr) m_state = 0;
                else if (m_tick == T - 1) begin
                    m_tick = 0;
                    if (m_bsec < 6) m_bsec++;
                end else begin
                    m_tick++;
                end
            end
        endcase
        m_mag = (m_state == 1) && (m_phase <= m_pow);
    endtask

    task automatic compare_all();
        bit exp_beep;
`ifdef BEEP_EN
        exp_beep = (m_state == 3) && (m_bsec < 6) && (m_bsec % 2 == 0);
`else
        exp_beep = 1'b0;
`endif
        check("state", 32'(panel.state), 32'(m_state));
        check("digits", 32'(dut_disp()), 32'(m_disp()));
        check("mag_on", 32'(panel.mag_on), 32'(m_mag && panel.door_closed));
        check("done", 32'(panel.done), 32'(m_state == 3));
        check("beep", 32'(panel.beep), 32'(exp_beep));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic press_key(input logic [3:0] d);
        panel.digit = d;
        panel.digit_valid = 1'b1;
        step();
        panel.digit_valid = 1'b0;
    endtask

    task automatic press_start();
        panel.startn = 1'b0;
        step();
        panel.startn = 1'b1;
    endtask

    task automatic press_clear();
        panel.clearn = 1'b0;
        step();
        panel.clearn = 1'b1;
    endtask

    task automatic run_to(input int target, input int budget, input string tag);
        int n = 0;
        while (m_state != target && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(panel.state), 32'(target));
    endtask

    task automatic idle_inputs();
        panel.startn = 1'b1; panel.stopn = 1'b1; panel.clearn = 1'b1;
        panel.door_closed = 1'b1; panel.digit_valid = 1'b0; panel.digit = 4'd0;
        panel.power = 2'd0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, dones, prev;
        idle_inputs();
        model_reset();
        @(negedge clk);
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        $display("reset: state %0d digits %04h", panel.state, dut_disp());

        press_key(4'd0); press_key(4'd1); press_key(4'd0); press_key(4'd5);
        check("keys_0105", 32'(dut_disp()), 32'h0105);
        press_key(4'd12);
        check("key12_ignored", 32'(dut_disp()), 32'h0105);
        $display("entry: digits %04h", dut_disp());

        panel.power = 2'd3;
        press_start();
        check("mag_after_start", 32'(panel.mag_on), 32'd1);
        repeat (4) step();
        check("after_4clk", 32'(dut_disp()), 32'h0104);
        run_to(3, 400, "cook_0105_done");
        check("done_flag", 32'(panel.done), 32'd1);
        check("done_mag_off", 32'(panel.mag_on), 32'd0);
        repeat (30) step();
        press_clear();
        $display("cook 01:05 p3: reached DONE, cleared to state %0d", panel.state);

        press_key(4'd2);
        press_start();
        repeat (2) step();
        panel.door_closed = 1'b0;
        #1;
        check("door_kill", 32'(panel.mag_on), 32'd0);
        step();
        check("door_pause", 32'(panel.state), 32'd2);
        repeat (3) step();
        panel.door_closed = 1'b1;
        press_start();
        check("door_resume", 32'(panel.state), 32'd1);
        run_to(3, 40, "door_resume_done");
        press_clear();
        $display("cook 00:02 door pause/resume: done");

        panel.power = 2'd0;
        press_key(4'd8);
        press_start();
        hi = int'(panel.mag_on);
        for (int n = 0; n < 60 && m_state != 3; n++) begin
            step();
            hi += int'(panel.mag_on);
        end
        check("pow0_mag_cycles", 32'(hi), 32'd8);
        press_clear();
        $display("cook 00:08 p0: mag_on cycles %0d", hi);

        press_start();
        check("start_zero_idle", 32'(panel.state), 32'd0);
        press_key(4'd5);
        panel.door_closed = 1'b0;
        press_start();
        panel.door_closed = 1'b1;
        check("start_door_open", 32'(panel.state), 32'd0);
        press_start();
        step();
        panel.stopn = 1'b0;
        step();
        panel.stopn = 1'b1;
        check("stop_pause", 32'(panel.state), 32'd2);
        panel.clearn = 1'b0;
        panel.startn = 1'b0;
        step();
        idle_inputs();
        check("pause_clear_start", 32'(panel.state), 32'd0);
        check("pause_clear_digits", 32'(dut_disp()), 32'h0000);
        $display("ignored starts and pause clear: state %0d digits %04h", panel.state, dut_disp());

        dones = 0;
        for (int n = 0; n < 15000; n++) begin
            panel.startn      = ($urandom_range(0, 9) != 0);
            panel.stopn       = ($urandom_range(0, 59) != 0);
            panel.clearn      = ($urandom_range(0, 299) != 0);
            panel.door_closed = ($urandom_range(0, 79) != 0);
            panel.digit_valid = ($urandom_range(0, 4) == 0);
            panel.digit       = 4'($urandom_range(0, 15));
            panel.power       = 2'($urandom_range(0, 3));
            prev = m_state;
            step();
            if (prev != 3 && m_state == 3) dones++;
        end
        idle_inputs();
        press_clear();
        $display("random: 15000 cycles, %0d completions", dones);

        press_key(4'd3);
        panel.power = 2'd2;
        press_start();
        repeat (3) step();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_state", 32'(panel.state), 32'd0);
        check("rst_digits", 32'(dut_disp()), 32'h0000);
        check("rst_mag", 32'(panel.mag_on), 32'd0);
        check("rst_done", 32'(panel.done), 32'd0);
        check("rst_beep", 32'(panel.beep), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        step();
        $display("async reset mid-cook: state %0d digits %04h", panel.state, dut_disp());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
